// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared defines for the PC fetch stage: FSM states, redirect source tags,
// chip-enable levels and the default reset PC / fetch granule.
package pc_fetch_ctrl_pkg;

    localparam logic        ChipEnable          = 1'b1;
    localparam logic        ChipDisable         = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam int          DEFAULT_FETCH_BYTES = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,   // fetch disabled, pc parked at RESET_PC
        ST_RUN   = 2'd1,   // no redirect waiting
        ST_PEND  = 2'd2    // redirect latched, waiting for an advance
    } fetch_state_e;

    typedef enum logic {
        SRC_BRANCH = 1'b0,
        SRC_FLUSH  = 1'b1
    } redir_src_e;

    // Clear the low offset bits of a target so it lands on a fetch granule.
    function automatic logic [31:0] align_addr(input logic [31:0] a, input int fb);
        logic [31:0] mask;
        mask = 32'(fb - 1);
        return a & ~mask;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect latch: holds one redirect target plus its source while the
// fetch stage cannot advance. A flush always overwrites; a branch overwrites
// only an empty slot or an earlier branch.
module pc_redirect_buf
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              capture_en_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o,
    output redir_src_e        src_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;
    redir_src_e        src_q, src_d;

    // Decide what the slot holds next cycle.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        src_d    = src_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            target_d = '0;
            src_d    = SRC_BRANCH;
        end else if (capture_en_i) begin
            if (flush_i) begin
                valid_d  = 1'b1;
                target_d = flush_target_i;
                src_d    = SRC_FLUSH;
            end else if (branch_i && (!valid_q || src_q == SRC_BRANCH)) begin
                valid_d  = 1'b1;
                target_d = branch_target_i;
                src_d    = SRC_BRANCH;
            end
        end
    end

    // Slot register; reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
            src_q    <= SRC_BRANCH;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
            src_q    <= src_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;
    assign src_o    = src_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: sequential fetch with zero-bubble flush/branch redirect
// and a one-entry pending slot for redirects arriving while the stage is held.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect reporting).
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FETCH_BYTES = DEFAULT_FETCH_BYTES,
    parameter int                STALL_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_target_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               inst_gnt_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               misalign_o,
    output logic [ADDR_W-1:0]  misalign_addr_o
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(FETCH_BYTES - 1);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(FETCH_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              advance;
    logic              active;
    logic [ADDR_W-1:0] flush_tgt_al, branch_tgt_al;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    redir_src_e        pend_src;

    // Only stall[0] gates this stage; upper bits belong to later stages.
    generate
        if (STALL_W > 1) begin : g_stall_unused
            logic unused_stall;
            assign unused_stall = ^stall[STALL_W-1:1];
        end
    endgenerate

    assign active        = (state_q != ST_RESET);
    assign advance       = ce & ~stall[0] & inst_gnt_i;
    assign flush_tgt_al  = flush_target_i & ~OFF_MASK;
    assign branch_tgt_al = branch_target_address_i & ~OFF_MASK;

    pc_redirect_buf #(
        .ADDR_W(ADDR_W)
    ) u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (advance),
        .capture_en_i   (active & ~advance),
        .flush_i        (flush_i),
        .flush_target_i (flush_tgt_al),
        .branch_i       (branch_flag_i),
        .branch_target_i(branch_tgt_al),
        .valid_o        (pend_valid),
        .target_o       (pend_target),
        .src_o          (pend_src)
    );

    // The source tag is only consulted inside the redirect buffer.
    logic unused_src;
    assign unused_src = pend_src;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_RESET;
        else      state_q <= state_d;
    end

    // FSM next state: PEND whenever a redirect is stuck behind a held stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   if (!advance && (flush_i || branch_flag_i)) state_d = ST_PEND;
            ST_PEND:  if (advance) state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // FSM outputs: fetch is enabled in every state except RESET.
    always_comb begin
        ce = ChipDisable;
        if (state_q != ST_RESET) ce = ChipEnable;
    end

    // Next-PC mux: flush > branch > pending > sequential (wraps naturally).
    always_comb begin
        pc_d = pc_q + INC;
        if (flush_i)            pc_d = flush_tgt_al;
        else if (branch_flag_i) pc_d = branch_tgt_al;
        else if (pend_valid)    pc_d = pend_target;
    end

    // PC register moves only on an accepted fetch.
    always_ff @(posedge clk) begin
        if (!rst)         pc_q <= RESET_PC;
        else if (advance) pc_q <= pc_d;
    end

    assign pc = pc_q;

`ifdef PC_ALIGN_CHECK_EN
    logic              mis_q;
    logic [ADDR_W-1:0] mis_addr_q;
    logic [ADDR_W-1:0] raw_tgt;
    logic              mis_hit;

    // The flush target is the one being acted on whenever flush is present.
    assign raw_tgt = flush_i ? flush_target_i : branch_target_address_i;
    assign mis_hit = active & (flush_i | branch_flag_i) & (|(raw_tgt & OFF_MASK));

    // One-cycle pulse after an offending target; address held until the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q <= mis_hit;
            if (mis_hit) mis_addr_q <= raw_tgt;
        end
    end

    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000 (ADDR_W bits): first fetch address after reset.
REQ-003 Parameter FETCH_BYTES, default 4: sequential increment; power of two, at least 1.
REQ-004 Parameter STALL_W, default 6: stall vector width; only bit 0 is used.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 stall  in  STALL_W  pipeline stall vector; stall[0]=1 freezes the PC stage.
REQ-008 flush_i  in  1  exception/flush redirect request.
REQ-009 flush_target_i  in  ADDR_W  flush redirect address.
REQ-010 branch_flag_i  in  1  branch-taken redirect request.
REQ-011 branch_target_address_i  in  ADDR_W  branch redirect address.
REQ-012 inst_gnt_i  in  1  instruction memory accepts the current fetch this cycle.
REQ-013 pc  out  ADDR_W  current fetch address.
REQ-014 ce  out  1  fetch enable; also acts as the fetch request to instruction memory.
REQ-015 misalign_o  out  1  one-cycle pulse flagging a misaligned redirect target.
REQ-016 misalign_addr_o  out  ADDR_W  offending target, held until the next pulse.

Function
REQ-017 States: RESET (ce=0), RUN (no redirect pending), PEND (redirect latched, not yet applied).
REQ-018 Advance condition: advance = ce & ~stall[0] & inst_gnt_i.
REQ-019 Next-PC priority on advance: flush_i > branch_flag_i > pending target > pc+FETCH_BYTES.
REQ-020 A redirect presented in a cycle with advance=1 loads pc on that clock edge, i.e. zero bubbles.
REQ-021 A redirect presented in a cycle with advance=0 latches its target and moves to PEND; pc holds.
REQ-022 In PEND, a later flush_i overwrites the latched target; a later branch overwrites it only if the latched target came from a branch.
REQ-023 In PEND with advance=1, the pending target is loaded into pc (unless a new flush/branch has higher priority), then the state returns to RUN.
REQ-024 With no advance, pc, state and the pending target hold exactly.
REQ-025 Sequential increment wraps modulo 2^ADDR_W: all-ones-aligned PC plus FETCH_BYTES gives 0, with no error flag.
REQ-026 Redirect targets have their low log2(FETCH_BYTES) bits forced to zero before use.
REQ-027 flush_i and branch_flag_i asserted in the same cycle: the flush wins and the branch is discarded, not queued.

Reset
REQ-028 While rst=0: state=RESET, ce=0, pc=RESET_PC, pending target cleared, misalign_o=0, misalign_addr_o=0.
REQ-029 First clock edge with rst=1: state becomes RUN and ce becomes 1; pc stays RESET_PC, and the first fetch address is RESET_PC.
REQ-030 Reset asserted mid-operation (including in PEND) discards any pending redirect on that edge.
REQ-031 In RESET, flush, branch and stall inputs are ignored.

Configuration
REQ-032 Macro PC_ALIGN_CHECK_EN defined: a redirect target with nonzero low bits pulses misalign_o for one cycle (the cycle after it is presented) and loads misalign_addr_o with the raw target; the redirect is still taken, aligned per REQ-026.
REQ-033 Macro PC_ALIGN_CHECK_EN undefined: misalign_o and misalign_addr_o are tied to 0, and alignment is silent.

Structure
REQ-034 The state enum, default RESET_PC and FETCH_BYTES constants belong in the shared defines package alongside ChipEnable/ChipDisable.
REQ-035 The pending-redirect latch (target, source, valid) is one sub-module, pc_redirect_buf; next-PC muxing stays in pc_fetch_ctrl.

Verification
REQ-036 Reset and sequential fetch: rst=0 for 3 cycles, then rst=1, inst_gnt_i=1, stall=0 -> ce=0 during reset; pc=0, 4, 8, 12 on successive cycles after release.
REQ-037 Branch with no stall: branch_flag_i=1, target 0x100, while pc=0x8 -> next pc=0x100, then 0x104.
REQ-038 Branch while stalled: stall[0]=1, branch to 0x200 held for one cycle, stall released 3 cycles later -> pc holds, then goes to 0x200, not pc+4.
REQ-039 Simultaneous flush and branch: flush to 0x80, branch to 0x300 in the same cycle -> pc=0x80, and the branch is never taken.
REQ-040 Flush overrides pending: branch to 0x300 latched under inst_gnt_i=0, then flush to 0x80, then gnt=1 -> pc=0x80.
REQ-041 Wrap and misalign (ADDR_W=32, PC_ALIGN_CHECK_EN): pc=0xFFFF_FFFC advances to 0x0; branch to 0x102 -> pc=0x100, misalign_o pulses once, misalign_addr_o=0x102.
